// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signal bundle for mem_arbiter.
// The master modport is the arbiter's view; slave is the environment's.
interface mem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            req_done;
  logic [NUM_PORTS-1:0]            req_err;
  logic [DATA_WIDTH-1:0]           rsp_rdata;
  logic                            busy;
  logic [GW-1:0]                   grant_id;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_write_data;
  logic                            mem_read;
  logic                            mem_write;
  logic [DATA_WIDTH-1:0]           mem_read_data;
  logic                            mem_ready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mem_read_data, mem_ready,
    output req_done, req_err, rsp_rdata, busy, grant_id,
           mem_addr, mem_write_data, mem_read, mem_write
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mem_read_data, mem_ready,
    input  req_done, req_err, rsp_rdata, busy, grant_id,
           mem_addr, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-beat memory port among NUM_PORTS requesters using
// fixed-priority or round-robin selection, with a response watchdog.
module mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);
  localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [GW-1:0]           last_q, last_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]    done_q, done_d;
  logic [NUM_PORTS-1:0]    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [NUM_PORTS-1:0]    eligible;
  logic                    found;
  logic [GW-1:0]           win;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_write;

  // The channel completing this cycle is masked so it cannot be re-accepted
  // while its requester is still dropping req_valid.
  always_comb begin
    eligible  = bus.req_valid & ~done_q & ~err_q;
    found     = 1'b0;
    win       = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    if (RR_MODE == 0) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (!found && eligible[i]) begin
          found = 1'b1;
          win   = GW'(i);
        end
      end
    end else begin
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          if (!found && eligible[i] &&
              (i == (32'(last_q) + k) % 32'(NUM_PORTS))) begin
            found = 1'b1;
            win   = GW'(i);
          end
        end
      end
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (win == GW'(i)) begin
        sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_write = bus.req_write[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    err_d   = '0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = win;
          last_d  = win;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          write_d = sel_write;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          done_d  = NUM_PORTS'(1) << grant_q;
          if (!write_q) rdata_d = bus.mem_read_data;
          state_d = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          err_d   = NUM_PORTS'(1) << grant_q;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_PORTS - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory bus is gated by state so it reads as zero whenever idle.
  assign bus.busy           = (state_q == BUSY);
  assign bus.grant_id       = grant_q;
  assign bus.req_done       = done_q;
  assign bus.req_err        = err_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.mem_addr       = (state_q == BUSY) ? addr_q  : '0;
  assign bus.mem_write_data = (state_q == BUSY) ? wdata_q : '0;
  assign bus.mem_read       = (state_q == BUSY) && !write_q;
  assign bus.mem_write      = (state_q == BUSY) && write_q;
endmodule
